// File: rtl/sect239k1_pt_mul_host.sv
// sect239k1_pt_mul_host
// Host-side serial front end that acts as the initiator of sect239k1_pt_mul.
// A frame is one sync bit (1) followed by DW scalar bits, MSB first. The
// scalar is handed to the multiplier, the block waits for done, and the
// result {x,y} goes back out MSB first (x[DW-1] first, y[0] last).
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   abort             synchronous soft abort, highest priority in any state
//   rx_bit, rx_valid  serial input, one bit per cycle while rx_valid is high
//   tx_bit, tx_valid  serial output
//   tx_ready          output sink ready
//   busy              high whenever the FSM is not idle
//   err               sticky timeout / rx-overrun flag, cleared by a sync bit
//   pm_clr, pm_start  one-cycle pulses to the multiplier
//   pm_d              scalar to the multiplier
//   pm_done, pm_x, pm_y  multiplier completion and result
//   dbg_state         current FSM state (state_t encoding)
//
// Output handshake: a bit moves on every rising edge where tx_valid and
// tx_ready are both high. While tx_ready is low, tx_valid and tx_bit stay
// unchanged. The input side has no backpressure: rx_valid marks a bit that
// is consumed in that cycle.
module sect239k1_pt_mul_host #(
  parameter int DW      = 239,
  parameter int TO_W    = 24,
  parameter int TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          abort,
  input  logic          rx_bit,
  input  logic          rx_valid,
  output logic          tx_bit,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          err,
  output logic          pm_clr,
  output logic          pm_start,
  output logic [DW-1:0] pm_d,
  input  logic          pm_done,
  input  logic [DW-1:0] pm_x,
  input  logic [DW-1:0] pm_y,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_SEND  = 3'd4
  } state_t;

  // One counter serves both the receive and the send phase, so it must
  // hold 2*DW-1 without wrapping.
  localparam int             CW      = $clog2(2 * DW);
  localparam logic [CW-1:0]  D_LAST  = CW'(DW - 1);
  localparam logic [CW-1:0]  S_LAST  = CW'(2 * DW - 1);
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [DW-1:0]     d_q, d_d;
  logic [2*DW-1:0]   sh_q, sh_d;
  logic              err_q, err_d;
  logic              clr_q, clr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    d_d     = d_q;
    sh_d    = sh_q;
    err_d   = err_q;
    clr_d   = 1'b0;
    if (abort) begin
      // pm_d and err are deliberately left alone.
      state_d = S_IDLE;
      cnt_d   = '0;
      to_d    = '0;
      clr_d   = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_valid && rx_bit) begin
            state_d = S_RECV;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
        S_RECV: begin
          if (rx_valid) begin
            d_d   = {d_q[DW-2:0], rx_bit};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == D_LAST) begin
              state_d = S_START;
              cnt_d   = '0;
            end
          end
        end
        S_START: begin
          state_d = S_WAIT;
          to_d    = '0;
        end
        S_WAIT: begin
          if (pm_done) begin
            sh_d    = {pm_x, pm_y};
            state_d = S_SEND;
            cnt_d   = '0;
          end else if ((TIMEOUT != 0) && (to_q == TO_LAST)) begin
            err_d   = 1'b1;
            clr_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            sh_d  = {sh_q[2*DW-2:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == S_LAST) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      // Input bits arriving while a multiply is in flight are dropped.
      if (rx_valid && ((state_q == S_START) || (state_q == S_WAIT) ||
                       (state_q == S_SEND))) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      d_q     <= '0;
      sh_q    <= '0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      d_q     <= d_d;
      sh_q    <= sh_d;
      err_q   <= err_d;
      clr_q   <= clr_d;
    end
  end

  assign tx_valid  = (state_q == S_SEND);
  // Gated so a result left behind by an abort never shows on the line.
  assign tx_bit    = tx_valid & sh_q[2*DW-1];
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign pm_clr    = clr_q;
  assign pm_start  = (state_q == S_START);
  assign pm_d      = d_q;
  assign dbg_state = state_q;

endmodule
